// File: rtl/clk_mon_pkg.sv
// rtl/clk_mon_pkg.sv - clk_mon state encoding, parameter defaults and helpers
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } state_e;

    localparam int DEF_EXP_PERIOD = 12;
    localparam int DEF_TOL        = 1;
    localparam int DEF_LOCK_CNT   = 4;
    localparam int DEF_TIMEOUT    = 32;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with rising-edge detect
module sync_edge (
    input  logic clk_in,
    input  logic reset,
    input  logic mon_in,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= mon_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/clk_mon.sv
// rtl/clk_mon.sv - monitored-clock period measurement, lock and loss detection
module clk_mon
    import clk_mon_pkg::*;
#(
    parameter int EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int TOL        = DEF_TOL,
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       mon_in,
    output logic [7:0] period,
    output logic       period_valid,
    output logic       locked,
    output logic       lost,
    output logic [7:0] err_cnt
);

    localparam logic [8:0] EXP9    = 9'(EXP_PERIOD);
    localparam logic [8:0] TOL9    = 9'(TOL);
    localparam logic [7:0] LOCK8   = 8'(LOCK_CNT);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] good_q, good_d;
    logic [7:0] period_q, period_d;
    logic       pv_q, pv_d;
    logic [7:0] err_q, err_d;
    logic       locked_q, lost_q;

    logic       rise;
    logic [7:0] measured;
    logic [8:0] meas9;
    logic [8:0] diff9;
    logic       in_win;
    logic       timeout;
    logic [7:0] good_inc;

    sync_edge u_sync_edge (
        .clk_in (clk_in),
        .reset  (reset),
        .mon_in (mon_in),
        .rise_o (rise)
    );

    assign measured = sat_inc(cnt_q);
    assign meas9    = {1'b0, measured};
    assign diff9    = (meas9 >= EXP9) ? (meas9 - EXP9) : (EXP9 - meas9);
    assign in_win   = (diff9 <= TOL9);
    // An edge in the same cycle as the timeout always wins.
    assign timeout  = !rise && (cnt_q == TO_LAST);
    assign good_inc = good_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = rise ? 8'd0 : sat_inc(cnt_q);
        good_d   = good_q;
        period_d = period_q;
        pv_d     = 1'b0;
        err_d    = err_q;
        case (state_q)
            ST_IDLE, ST_LOST: begin
                if (rise) begin
                    state_d = ST_MEASURE;
                    good_d  = 8'd0;
                end else if (timeout) begin
                    state_d = ST_LOST;
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    period_d = measured;
                    pv_d     = 1'b1;
                    if (!in_win) begin
                        good_d = 8'd0;
                    end else if (good_inc >= LOCK8) begin
                        state_d = ST_LOCKED;
                        good_d  = 8'd0;
                    end else begin
                        good_d = good_inc;
                    end
                end else if (timeout) begin
                    state_d = ST_LOST;
                end
            end
            ST_LOCKED: begin
                if (rise) begin
                    period_d = measured;
                    pv_d     = 1'b1;
                    if (!in_win) begin
                        state_d = ST_MEASURE;
                        good_d  = 8'd0;
                        err_d   = sat_inc(err_q);
                    end
                end else if (timeout) begin
                    state_d = ST_LOST;
                    err_d   = sat_inc(err_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            good_q   <= 8'd0;
            period_q <= 8'd0;
            pv_q     <= 1'b0;
            err_q    <= 8'd0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            err_q    <= err_d;
            locked_q <= (state_d == ST_LOCKED);
            lost_q   <= (state_d == ST_LOST);
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign lost         = lost_q;
    assign err_cnt      = err_q;

endmodule

// File: tb/tb_clk_mon.sv
// tb/tb_clk_mon.sv - randomized bench for clk_mon against a behavioural model
module tb_clk_mon;

    localparam int EXP  = 12;
    localparam int TOL  = 1;
    localparam int LOCK = 4;
    localparam int TO   = 32;

    localparam int M_IDLE = 0;
    localparam int M_MEAS = 1;
    localparam int M_LOCK = 2;
    localparam int M_LOST = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       mon;
    logic [7:0] period;
    logic       period_valid;
    logic       locked;
    logic       lost;
    logic [7:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    clk_mon #(
        .EXP_PERIOD (EXP),
        .TOL        (TOL),
        .LOCK_CNT   (LOCK),
        .TIMEOUT    (TO)
    ) dut (
        .clk_in       (clk),
        .reset        (rst),
        .mon_in       (mon),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .lost         (lost),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    // Model: edges are derived from the raw mon_in history, periods from the
    // distance in clock samples between consecutive edges.
    int  t       = 0;
    bit  started = 0;
    bit  hist[$];
    int  m_state = M_IDLE;
    int  m_last  = 0;
    int  m_good  = 0;
    int  m_period = 0;
    int  m_pv    = 0;
    int  m_err   = 0;

    function automatic bit hist_at(int k);
        if (hist.size() > k) return hist[hist.size() - 1 - k];
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        int  gap, meas;
        bit  e, win;
        t = t + 1;
        started = 1;
        if (rst) begin
            hist.delete();
            m_state = M_IDLE; m_last = t; m_good = 0;
            m_period = 0; m_pv = 0; m_err = 0;
        end else begin
            e    = hist_at(1) && !hist_at(2);
            gap  = t - m_last;
            meas = (gap > 255) ? 255 : gap;
            win  = (meas - EXP <= TOL) && (EXP - meas <= TOL);
            m_pv = 0;
            if (e) begin
                m_last = t;
                case (m_state)
                    M_IDLE, M_LOST: begin m_state = M_MEAS; m_good = 0; end
                    M_MEAS: begin
                        m_period = meas; m_pv = 1;
                        if (win) begin
                            m_good++;
                            if (m_good >= LOCK) begin m_state = M_LOCK; m_good = 0; end
                        end else m_good = 0;
                    end
                    default: begin
                        m_period = meas; m_pv = 1;
                        if (!win) begin
                            m_state = M_MEAS; m_good = 0;
                            m_err = (m_err < 255) ? m_err + 1 : 255;
                        end
                    end
                endcase
            end else if (gap == TO && m_state != M_LOST) begin
                if (m_state == M_LOCK) m_err = (m_err < 255) ? m_err + 1 : 255;
                m_state = M_LOST;
            end
            hist.push_back(mon);
            if (hist.size() > 4) void'(hist.pop_front());
        end
    end

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, t);
        end
    endtask

    int last_pv_t   = 0;
    int lost_rise_t = 0;
    int pv_cnt      = 0;
    bit saw15       = 0;
    bit prev_lost   = 0;

    always @(negedge clk) begin
        if (started) begin
            chk("period",       int'(period),       m_period);
            chk("period_valid", int'(period_valid), m_pv);
            chk("locked",       int'(locked),       (m_state == M_LOCK) ? 1 : 0);
            chk("lost",         int'(lost),         (m_state == M_LOST) ? 1 : 0);
            chk("err_cnt",      int'(err_cnt),      m_err);
            if (period_valid === 1'b1) begin
                last_pv_t = t;
                pv_cnt++;
                if (period == 8'd15) saw15 = 1;
            end
            if (lost === 1'b1 && !prev_lost) lost_rise_t = t;
            prev_lost = (lost === 1'b1);
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_period(int p, int hi);
        mon = 1'b1; cyc(hi);
        mon = 1'b0; cyc(p - hi);
    endtask

    task automatic per(int p, int n);
        repeat (n) drive_period(p, p / 2);
    endtask

    task automatic do_reset(int n);
        rst = 1'b1; cyc(n); rst = 1'b0;
    endtask

    initial begin
        int r, p;
        rst = 1'b1; mon = 1'b0;
        cyc(3);
        rst = 1'b0;
        chk("rst_period", int'(period), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_lost",   int'(lost),   0);
        chk("rst_err",    int'(err_cnt), 0);

        // Nominal period 12, then one long period and recovery
        per(12, 8);
        chk("nom_locked", int'(locked), 1);
        chk("nom_period", int'(period), 12);
        chk("nom_err",    int'(err_cnt), 0);
        saw15 = 0;
        per(15, 1);
        per(12, 5);
        chk("p15_seen",   int'(saw15), 1);
        chk("p15_err",    int'(err_cnt), 1);
        chk("p15_relock", int'(locked), 1);

        // Loss of mon_in while locked
        mon = 1'b0; cyc(50);
        chk("loss_lost",  int'(lost), 1);
        chk("loss_delay", lost_rise_t - last_pv_t, 32);
        chk("loss_err",   int'(err_cnt), 2);

        // Alternating 11/13 locks; a 10 breaks the run
        repeat (5) begin per(11, 1); per(13, 1); end
        chk("alt_locked", int'(locked), 1);
        mon = 1'b0; cyc(40);
        per(12, 2); per(10, 1); per(12, 4);
        chk("p10_nolock", int'(locked), 0);

        // Reset in the middle of a locked stream
        per(12, 8);
        mon = 1'b1; cyc(3);
        do_reset(2);
        mon = 1'b0;
        chk("mid_period", int'(period), 0);
        chk("mid_locked", int'(locked), 0);
        chk("mid_err",    int'(err_cnt), 0);
        per(12, 6);
        chk("mid_relock", int'(locked), 1);

        // Static mon_in from reset, then a single edge
        do_reset(2);
        cyc(40);
        chk("static_lost", int'(lost), 1);
        pv_cnt = 0;
        per(12, 1);
        chk("static_nopv", pv_cnt, 0);
        chk("static_rearm", int'(lost), 0);

        // Randomized periods, including timeout-boundary and saturating gaps
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      p = $urandom_range(10, 14);
            else if (r < 80) p = $urandom_range(2, 9);
            else if (r < 90) p = $urandom_range(30, 34);
            else if (r < 97) p = $urandom_range(35, 300);
            else p = 0;
            if (p == 0) do_reset($urandom_range(1, 2));
            else drive_period(p, $urandom_range(1, p - 1));
        end

        // Drive err_cnt into saturation
        do_reset(2);
        per(12, 5);
        repeat (260) begin per(20, 1); per(12, 4); end
        per(12, 1);
        chk("err_sat",    int'(err_cnt), 255);
        chk("sat_locked", int'(locked), 1);

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_mon.md
CLK_MON -- requirements
Module: clk_mon

Interface
REQ-001 Parameter EXP_PERIOD, default 12, expected mon_in period in clk_in cycles (matches divide-by-12 clock output).
REQ-002 Parameter TOL, default 1, allowed absolute period deviation in cycles.
REQ-003 Parameter LOCK_CNT, default 4, consecutive in-window periods required for lock.
REQ-004 Parameter TIMEOUT, default 32, cycles without a rising edge before loss is declared; legal range 2..255.
REQ-005 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 mon_in  input  1  monitored clock; asynchronous to clk_in.
REQ-008 period  output  8  last measured period in clk_in cycles.
REQ-009 period_valid  output  1  one-cycle strobe when period updates.
REQ-010 locked  output  1  high in LOCKED state.
REQ-011 lost  output  1  high in LOST state.
REQ-012 err_cnt  output  8  saturating count of lock-loss events.

Function
REQ-013 mon_in SHALL pass a 2-flop synchronizer; a rising edge (edge) is sync=1 and previous sync=0, detected 3 clk_in cycles after the mon_in transition.
REQ-014 Gap counter cnt (8 bits) SHALL clear to 0 on each edge cycle, else increment, saturating at 255.
REQ-015 Measured value on an edge SHALL be cnt+1 (saturating at 255), i.e. cycles between consecutive edge cycles.
REQ-016 In-window: |measured - EXP_PERIOD| <= TOL, computed at 9 bits, no wrap.
REQ-017 States: IDLE, MEASURE, LOCKED, LOST; good_cnt tracks consecutive in-window periods.
REQ-018 IDLE: edge -> MEASURE, good_cnt=0, no period_valid; cnt reaching TIMEOUT-1 without edge -> LOST.
REQ-019 MEASURE: edge -> period updated, period_valid=1; in-window increments good_cnt, reaching LOCK_CNT -> LOCKED; out-of-window clears good_cnt.
REQ-020 MEASURE: timeout -> LOST, err_cnt unchanged.
REQ-021 LOCKED: in-window edge -> update period, stay; out-of-window edge -> MEASURE, good_cnt=0, err_cnt+1; timeout -> LOST, err_cnt+1.
REQ-022 LOST: edge -> MEASURE, good_cnt=0, no period_valid (first edge only re-arms).
REQ-023 Edge and timeout in same cycle: edge SHALL win.
REQ-024 err_cnt SHALL saturate at 255.
REQ-025 locked/lost SHALL be registered decodes of state, updating the cycle after the transition edge.

Reset
REQ-026 On reset: state=IDLE, cnt=0, good_cnt=0, period=0, period_valid=0, locked=0, lost=0, err_cnt=0, synchronizer and edge flops=0.
REQ-027 Reset mid-measurement SHALL discard all history; first post-reset edge never yields period_valid.

Structure
REQ-028 Package clk_mon_pkg SHALL hold the state encoding and parameter defaults.
REQ-029 Sub-module sync_edge SHALL implement the 2-flop synchronizer plus rising-edge detect, with clk_in/reset ports.

Verification
REQ-030 mon_in toggling every 6 clk_in cycles (period 12) -> period_valid each 12 cycles with period=12; locked=1 after 5th edge; err_cnt=0.
REQ-031 Locked, then one period of 15 -> period=15, locked=0, err_cnt=1; 4 good periods later locked=1.
REQ-032 Locked, mon_in held low -> lost=1 exactly TIMEOUT=32 cycles after last edge, err_cnt incremented.
REQ-033 Periods of 11 and 13 alternating -> locked reached (TOL=1); period 10 -> good_cnt cleared, no lock.
REQ-034 Reset asserted mid-lock, released, clock resumes -> all outputs 0, no period_valid on first edge, lock after 5 edges.
REQ-035 mon_in static from reset -> lost=1 after 32 cycles; first edge -> MEASURE, no period_valid.
